mem_bus_responder: RTL and testbench

Synthesizable memory-side responder for the CPU's cs/we/oe memory bus with a shared tristate data bus. The CPU fetch/execute sequencer drives MAR, cs, we and oe; this block answers as the target. It services reads and writes to an internal word array, inserts configurable wait states and signals completion with a one-cycle ready pulse. Bad requests return a one-cycle err pulse with an error code.

---
 rtl/mem_bus_pkg.sv | 23 ++
 rtl/mem_word_array.sv | 24 ++
 rtl/mem_bus_responder.sv | 136 +++++++++++++
 tb/tb_mem_bus_responder.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and error codes for the cs/we/oe memory bus responder.
// Imported by the responder top and its word array.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP,
    ERR
  } state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_PROTO    = 2'b11;

endpackage

// File: rtl/mem_word_array.sv
// Single-port word store: one synchronous write, registered read.
// Contents are deliberately left unreset.
module mem_word_array
  import mem_bus_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [1 << DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/mem_bus_responder.sv
// Target side of the cs/we/oe memory bus: classifies, waits,
// accesses the word array and answers with ready or err pulses.
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int ADDR_WIDTH  = 28,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe,
  output logic                  ready,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic                  busy
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
    $error("WAIT_STATES must be within 0..15");
  end

  state_t                state_q, state_d;
  op_t                   op_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [3:0]            cnt_q, cnt_d;
  logic                  ready_q, err_q, busy_q;
  logic                  drive_en_q;
  logic [1:0]            code_q, cls;
  logic                  accept, commit, rd_guard;

  assign accept   = (state_q == IDLE) && cs;
  assign commit   = (state_q == ACCESS) && cs;
  assign rd_guard = cs && oe && !we;

  // First matching class wins.
  always_comb begin
    cls = ERR_NONE;
    if (we == oe)
      cls = ERR_PROTO;
    else if (addr[0])
      cls = ERR_MISALIGN;
    else if (|addr[ADDR_WIDTH-1:DEPTH_LOG2+1])
      cls = ERR_RANGE;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (cs) begin
          if (cls != ERR_NONE) begin
            state_d = ERR;
          end else if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (!cs)
          state_d = IDLE;
        else if (cnt_q == 4'd1)
          state_d = ACCESS;
        else
          cnt_d = cnt_q - 4'd1;
      end
      ACCESS:  state_d = cs ? RESP : IDLE;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
      busy_q     <= 1'b0;
      drive_en_q <= 1'b0;
      op_q       <= OP_READ;
      idx_q      <= '0;
      wdata_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= commit;
      err_q   <= accept && (cls != ERR_NONE);
      code_q  <= accept ? cls : ERR_NONE;
      busy_q  <= (state_d != IDLE);
      if (accept) begin
        op_q    <= we ? OP_WRITE : OP_READ;
        idx_q   <= addr[DEPTH_LOG2:1];
        wdata_q <= data;
      end
      // Read data stays on the bus while the initiator holds the read.
      if (accept || !rd_guard)
        drive_en_q <= 1'b0;
      else if (commit && op_q == OP_READ)
        drive_en_q <= 1'b1;
    end
  end

  mem_word_array #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (commit && op_q == OP_WRITE),
    .re   (commit && op_q == OP_READ),
    .idx  (idx_q),
    .wdata(wdata_q),
    .rdata(rdata_q)
  );

  assign data = (drive_en_q && rd_guard) ? rdata_q : 'z;

  assign ready    = ready_q;
  assign err      = err_q;
  assign err_code = code_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder at 0, 2 and 3 wait states.
// Idle bus is pulled low, so a released bus reads back as zero.
module tb_mem_bus_responder;

  typedef struct {
    bit          er;
    logic [1:0]  code;
    logic [31:0] d;
    int          lat;
    int          busy;
  } exp_t;

  typedef struct {
    bit          rdy;
    bit          er;
    logic [1:0]  code;
    logic [31:0] d;
    logic [31:0] dz;
    int          lat;
    int          busy;
    bit          after_ok;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [27:0] a_s [3];
  logic [31:0] twd [3];
  logic [2:0]  cs_s = '0, we_s = '0, oe_s = '0, ten = '0;
  wire  [2:0]  rdy, er, bsy;
  wire  [5:0]  ec;

  logic [31:0] mdl [3][1024];
  exp_t        sb [$];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gi
    wire [31:0] d;
    pulldown (d);
    assign d = ten[g] ? twd[g] : 'z;
    mem_bus_responder #(
      .ADDR_WIDTH(28),
      .DATA_WIDTH(32),
      .DEPTH_LOG2(10),
      .WAIT_STATES((g == 0) ? 0 : g + 1)
    ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .addr    (a_s[g]),
      .data    (d),
      .cs      (cs_s[g]),
      .we      (we_s[g]),
      .oe      (oe_s[g]),
      .ready   (rdy[g]),
      .err     (er[g]),
      .err_code(ec[2*g+:2]),
      .busy    (bsy[g])
    );
  end

  function automatic int ws(input int i);
    return (i == 0) ? 0 : i + 1;
  endfunction

  function automatic logic [31:0] bus(input int i);
    case (i)
      0:       return gi[0].d;
      1:       return gi[1].d;
      default: return gi[2].d;
    endcase
  endfunction

  function automatic exp_t predict(input int i, input logic [27:0] a,
                                   input logic w, input logic o,
                                   input logic [31:0] wd);
    exp_t x;
    x.code = 2'b00;
    x.d    = '0;
    if (w == o)
      x.code = 2'b11;
    else if (a[0])
      x.code = 2'b01;
    else if (a[27:11] != 0)
      x.code = 2'b10;
    x.er   = (x.code != 2'b00);
    x.lat  = x.er ? 0 : 1 + ws(i);
    x.busy = x.lat + 1;
    if (!x.er && w) mdl[i][a[10:1]] = wd;
    if (!x.er && o) x.d = mdl[i][a[10:1]];
    return x;
  endfunction

  task automatic do_xact(input int i, input logic [27:0] a,
                         input logic w, input logic o,
                         input logic [31:0] wd,
                         output obs_t g, output exp_t e);
    int n;
    g = '{default: 0};
    sb.push_back(predict(i, a, w, o, wd));
    @(negedge clk);
    a_s[i] = a; we_s[i] = w; oe_s[i] = o;
    twd[i] = wd; ten[i] = w; cs_s[i] = 1'b1;
    @(posedge clk);
    #1 ten[i] = 1'b0;
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (bsy[i]) g.busy++;
      if (rdy[i] || er[i] || n > 40) break;
    end
    g.rdy  = rdy[i];
    g.er   = er[i];
    g.code = ec[2*i+:2];
    g.d    = bus(i);
    g.lat  = n - 1;
    oe_s[i] = 1'b0;
    #1 g.dz = bus(i);
    cs_s[i] = 1'b0; we_s[i] = 1'b0;
    @(negedge clk);
    g.after_ok = !rdy[i] && !er[i] && !bsy[i];
    e = sb.pop_front();
  endtask

  task automatic test_reset();
    for (int p = 0; p < 2; p++) begin
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({rdy[i], er[i], bsy[i], ec[2*i+:2]} !== 5'b0) begin
          failures++;
          $display("FAIL reset_outs inst=%0d phase=%0d got=%b want=00000",
                   i, p, {rdy[i], er[i], bsy[i], ec[2*i+:2]});
        end
        checks++;
        if (bus(i) !== 32'h0) begin
          failures++;
          $display("FAIL reset_bus inst=%0d got=%h want=z(0)", i, bus(i));
        end
      end
      rst_n = 1'b1;
    end
  endtask

  task automatic test_basic();
    logic [27:0] ta [4] = '{28'h100, 28'h100, 28'h7FE, 28'h7FE};
    logic [31:0] td [4] = '{32'h1000011E, 0, 32'h5A5A0001, 0};
    obs_t g;
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      do_xact(0, ta[k], k[0] == 0, k[0] == 1, td[k], g, e);
      checks++;
      if ({g.rdy, g.er, g.code} !== {!e.er, e.er, e.code}) begin
        failures++;
        $display("FAIL basic_status k=%0d got=%b want=%b", k,
                 {g.rdy, g.er, g.code}, {!e.er, e.er, e.code});
      end
      checks++;
      if (g.lat !== e.lat || g.busy !== e.busy) begin
        failures++;
        $display("FAIL basic_timing k=%0d lat=%0d/%0d busy=%0d/%0d",
                 k, g.lat, e.lat, g.busy, e.busy);
      end
      checks++;
      if (g.d !== e.d || g.dz !== 32'h0 || !g.after_ok) begin
        failures++;
        $display("FAIL basic_data k=%0d got=%h z=%h end=%0d want=%h z=0 end=1",
                 k, g.d, g.dz, g.after_ok, e.d);
      end
    end
  endtask

  task automatic test_wait_states();
    obs_t g;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      do_xact(1, 28'h118, k == 0, k == 1, 32'h08000000, g, e);
      checks++;
      if ({g.rdy, g.er} !== 2'b10 || g.lat !== e.lat) begin
        failures++;
        $display("FAIL wait_ready k=%0d rdy=%0d err=%0d lat=%0d want lat=%0d",
                 k, g.rdy, g.er, g.lat, e.lat);
      end
      checks++;
      if (g.busy !== e.busy || !g.after_ok) begin
        failures++;
        $display("FAIL wait_busy k=%0d busy=%0d want=%0d end=%0d",
                 k, g.busy, e.busy, g.after_ok);
      end
      checks++;
      if (g.d !== e.d) begin
        failures++;
        $display("FAIL wait_data k=%0d got=%h want=%h", k, g.d, e.d);
      end
    end
  endtask

  task automatic test_errors();
    logic [27:0] ta [5] = '{28'h101, 28'h800, 28'h100, 28'h100, 28'h100};
    logic [1:0]  tw [5] = '{2'b01, 2'b01, 2'b11, 2'b00, 2'b01};
    obs_t g;
    exp_t e;
    for (int k = 0; k < 5; k++) begin
      do_xact(0, ta[k], tw[k][1], tw[k][0], 32'hDEADBEEF, g, e);
      checks++;
      if ({g.rdy, g.er, g.code} !== {!e.er, e.er, e.code}) begin
        failures++;
        $display("FAIL err_status k=%0d got=%b want=%b", k,
                 {g.rdy, g.er, g.code}, {!e.er, e.er, e.code});
      end
      checks++;
      if (g.lat !== e.lat || g.busy !== e.busy || !g.after_ok) begin
        failures++;
        $display("FAIL err_timing k=%0d lat=%0d/%0d busy=%0d/%0d end=%0d",
                 k, g.lat, e.lat, g.busy, e.busy, g.after_ok);
      end
      checks++;
      if (g.d !== e.d) begin
        failures++;
        $display("FAIL err_data k=%0d got=%h want=%h", k, g.d, e.d);
      end
    end
  endtask

  task automatic test_abort();
    obs_t g;
    exp_t e;
    int   seen;
    do_xact(2, 28'h102, 1'b1, 1'b0, 32'h00000120, g, e);
    @(negedge clk);
    a_s[2] = 28'h102; we_s[2] = 1'b1; oe_s[2] = 1'b0;
    twd[2] = 32'hB8000001; ten[2] = 1'b1; cs_s[2] = 1'b1;
    @(posedge clk);
    #1 ten[2] = 1'b0;
    repeat (2) @(negedge clk);
    cs_s[2] = 1'b0; we_s[2] = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy[2] || er[2]) seen++;
    end
    checks++;
    if (seen !== 0 || bsy[2] !== 1'b0) begin
      failures++;
      $display("FAIL abort_quiet pulses=%0d busy=%0d want=0/0", seen, bsy[2]);
    end
    do_xact(2, 28'h102, 1'b0, 1'b1, 32'h0, g, e);
    checks++;
    if (g.rdy !== 1'b1 || g.d !== e.d) begin
      failures++;
      $display("FAIL abort_readback rdy=%0d got=%h want=%h", g.rdy, g.d, e.d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v [4];
    obs_t g;
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      v[k] = $urandom;
      do_xact(0, 28'h200 + 28'(2 * k), 1'b1, 1'b0, v[k], g, e);
    end
    for (int k = 3; k >= 0; k--) begin
      do_xact(0, 28'h200 + 28'(2 * k), 1'b0, 1'b1, 32'h0, g, e);
      checks++;
      if (g.rdy !== 1'b1 || g.d !== e.d || g.lat !== e.lat) begin
        failures++;
        $display("FAIL b2b_read k=%0d rdy=%0d got=%h want=%h lat=%0d",
                 k, g.rdy, g.d, e.d, g.lat);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t g;
    exp_t e;
    int   n;
    do_xact(0, 28'h11A, 1'b1, 1'b0, 32'h7800000A, g, e);
    @(negedge clk);
    a_s[0] = 28'h11A; we_s[0] = 1'b0; oe_s[0] = 1'b1; cs_s[0] = 1'b1;
    @(posedge clk);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (rdy[0]) break;
    end
    checks++;
    if (rdy[0] !== 1'b1 || bus(0) !== 32'h7800000A) begin
      failures++;
      $display("FAIL rstmid_resp rdy=%0d data=%h want=1/7800000a",
               rdy[0], bus(0));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy[0], er[0], bsy[0]} !== 3'b000 || bus(0) !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_clear outs=%b data=%h want=000/z(0)",
               {rdy[0], er[0], bsy[0]}, bus(0));
    end
    cs_s[0] = 1'b0; oe_s[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_xact(0, 28'h11A, 1'b0, 1'b1, 32'h0, g, e);
    checks++;
    if (g.rdy !== 1'b1 || g.d !== e.d) begin
      failures++;
      $display("FAIL rstmid_keep rdy=%0d got=%h want=%h", g.rdy, g.d, e.d);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      a_s[i] = '0;
      twd[i] = '0;
    end
    test_reset();
    test_basic();
    test_wait_states();
    test_errors();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
